triangle_decoder: RTL and testbench
===================================

# triangle_decoder

Receiver for the triangular-pulse line. Samples the 8-bit offset-binary line (zero level 8'h80), recognises one triangular pulse (a ±1-per-clock ramp from zero followed by a single-step return to zero), recovers its sign `s` and height `h`, and delivers them to a downstream consumer over the standard `dav_`/`rfd` handshake, acting as the producer. It sits at the far end of the line driven by the triangle generator.

## Interface
Parameters: none (constants live in the package).
- clock  in  1  system clock; all state changes on posedge
- reset_  in  1  asynchronous, active-low reset
- in  in  8  sampled line, offset binary, 8'h80 = zero
- s  out  1  recovered sign: 0 = upward ramp, 1 = downward ramp
- h  out  7  recovered height (number of ramp samples, 128 encoded as 0)
- dav_  out  1  data valid, active low; `s`/`h` valid while low
- rfd  in  1  consumer ready-for-data
- err  out  1  one-clock pulse: malformed pulse discarded
- ovf  out  1  one-clock pulse: well-formed pulse dropped, holding register full

## Operation
- Reset values: dav_=1, s=0, h=0, err=0, ovf=0, holding register empty, capture FSM in SYNC, output FSM in O_IDLE.
- Capture FSM (registers: dir, last[7:0], cnt[7:0]):
  - SYNC: wait for a sample `in`==8'h80, then IDLE. Guarantees a pulse in flight at reset release is ignored, not mis-decoded.
  - IDLE: `in`==8'h81 -> RAMP, dir=0; `in`==8'h7F -> RAMP, dir=1; last=in, cnt=1. `in`==8'h80 stays. Any other value -> err, WAIT0.
  - RAMP: `in`==8'h80 -> pulse complete, h=cnt[6:0], s=dir, IDLE. `in`==last+1 (dir=0) or last−1 (dir=1), modulo 256, with cnt<128 -> cnt+1, last=in. Otherwise (wrong step, or 129th ramp sample) -> err, WAIT0.
  - WAIT0: wait for `in`==8'h80, then IDLE.
- Completion: if holding register empty, load {s,h}, mark full; if full, ovf pulse and discard new result. Holding register freed on the same edge -> treated as empty, new result accepted.
- Output FSM (producer side):
  - O_IDLE: dav_=1. If full and rfd==1 -> O_VALID, dav_<=0.
  - O_VALID: dav_=0. When rfd==0 -> dav_<=1, holding register empty, O_IDLE.
- `s`/`h` outputs change only on holding-register load; stable from load until dav_ rises.
- Height 128 (ramp reaching 8'h00 upward or 8'h00 downward) is legal, reported as h=0.

## Timing
- Line sampled at every posedge; one sample per ramp step.
- Pulse of height H: H ramp samples then 8'h80; result loaded at edge sampling the return to 8'h80.
- dav_ falls earliest one clock after load (rfd already 1). Rises one clock after rfd sampled 0.
- Back-to-back pulses: a new pulse may start on the sample immediately after the return to 8'h80.
- Reset asserted at any time: all outputs to reset values immediately; after release, no decode until a zero sample is seen.

## Structure
- Package `triangle_pkg`: ZERO_LEVEL=8'h80, MAX_STEPS=128, capture state encodings (SYNC, IDLE, RAMP, WAIT0), output state encodings (O_IDLE, O_VALID). Shared with the generator.
- Sub-module `dav_producer`: holding register plus output FSM (inputs load/data/rfd; outputs dav_, s, h, full). Capture FSM stays in top.

## Test plan
- Line 80,81,82,83,80 with rfd=1 -> s=0, h=3, dav_ low next clock; rfd->0 -> dav_ high one clock later.
- Line 80,7F,7E,80 -> s=1, h=2; line 80,7F..00 (128 samples),80 -> s=1, h=0; upward 81..FF,00,80 -> s=0, h=0.
- Line 80,81,83,80 -> err pulse on sample 83, no dav_ activity; next clean pulse 81,80 -> s=0, h=1.
- rfd held 0, two clean pulses -> first held in s/h, ovf pulse at end of second, dav_ delivers only first once rfd=1.
- reset_ low during ramp at 82, released at 84 -> no output until 80 seen; following pulse decoded correctly.

Source files
------------

// File: rtl/triangle_pkg.sv
// Shared constants and state encodings for the triangular-pulse line
// (used by both the generator and the decoder).
package triangle_pkg;

    localparam logic [7:0] ZERO_LEVEL = 8'h80;
    localparam logic [7:0] MAX_STEPS  = 8'd128;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        IDLE  = 2'd1,
        RAMP  = 2'd2,
        WAIT0 = 2'd3
    } cap_state_t;

    typedef enum logic {
        O_IDLE  = 1'b0,
        O_VALID = 1'b1
    } out_state_t;

    typedef struct packed {
        logic       s;
        logic [6:0] h;
    } result_t;

endpackage

// File: rtl/dav_producer.sv
// Single-entry holding register for a decoded pulse, presented to the
// consumer over the dav_/rfd handshake with this block as producer.
module dav_producer
    import triangle_pkg::*;
(
    input  logic       clock,
    input  logic       reset_,
    input  logic       load,
    input  logic [7:0] data,
    input  logic       rfd,
    output logic       dav_,
    output logic       s,
    output logic [6:0] h,
    output logic       full,
    output logic       free
);

    out_state_t state_reg, state_next;
    logic       full_reg, full_next;
    logic       dav_reg, dav_next;
    result_t    hold_reg, hold_next;

    // Register is released on this edge; a simultaneous load may reuse it.
    assign free = (state_reg == O_VALID) && !rfd;

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_reg <= O_IDLE;
            full_reg  <= 1'b0;
            dav_reg   <= 1'b1;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            full_reg  <= full_next;
            dav_reg   <= dav_next;
            hold_reg  <= hold_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        full_next  = full_reg;
        dav_next   = dav_reg;
        hold_next  = hold_reg;
        case (state_reg)
            O_IDLE: begin
                if (full_reg && rfd) begin
                    state_next = O_VALID;
                    dav_next   = 1'b0;
                end
            end
            O_VALID: begin
                if (!rfd) begin
                    state_next = O_IDLE;
                    dav_next   = 1'b1;
                    full_next  = 1'b0;
                end
            end
            default: begin
                state_next = O_IDLE;
                dav_next   = 1'b1;
            end
        endcase
        if (load && (!full_reg || free)) begin
            hold_next = result_t'(data);
            full_next = 1'b1;
        end
    end

    assign dav_ = dav_reg;
    assign s    = hold_reg.s;
    assign h    = hold_reg.h;
    assign full = full_reg;

endmodule

// File: rtl/triangle_decoder.sv
// Triangular-pulse line receiver: recognises one +/-1-per-clock ramp and its
// single-step return to zero, then hands {sign, height} to dav_producer.
module triangle_decoder
    import triangle_pkg::*;
(
    input  logic       clock,
    input  logic       reset_,
    input  logic [7:0] in,
    output logic       s,
    output logic [6:0] h,
    output logic       dav_,
    input  logic       rfd,
    output logic       err,
    output logic       ovf
);

    localparam logic [7:0] UP_FIRST   = ZERO_LEVEL + 8'd1;
    localparam logic [7:0] DOWN_FIRST = ZERO_LEVEL - 8'd1;

    cap_state_t state_reg, state_next;
    logic       dir_reg, dir_next;
    logic [7:0] last_reg, last_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       err_reg, err_next;
    logic       ovf_reg, ovf_next;
    logic       load;
    logic [7:0] step;
    logic       full;
    logic       free;

    // Next sample expected on the ramp (wraps modulo 256).
    assign step = dir_reg ? (last_reg - 8'd1) : (last_reg + 8'd1);

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_reg <= SYNC;
            dir_reg   <= 1'b0;
            last_reg  <= ZERO_LEVEL;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            dir_reg   <= dir_next;
            last_reg  <= last_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        last_next  = last_reg;
        cnt_next   = cnt_reg;
        err_next   = 1'b0;
        load       = 1'b0;
        case (state_reg)
            SYNC: begin
                if (in == ZERO_LEVEL) state_next = IDLE;
            end
            IDLE: begin
                if (in == UP_FIRST || in == DOWN_FIRST) begin
                    state_next = RAMP;
                    dir_next   = (in == DOWN_FIRST);
                    last_next  = in;
                    cnt_next   = 8'd1;
                end else if (in != ZERO_LEVEL) begin
                    state_next = WAIT0;
                    err_next   = 1'b1;
                end
            end
            RAMP: begin
                if (in == ZERO_LEVEL) begin
                    state_next = IDLE;
                    load       = 1'b1;
                end else if (in == step && cnt_reg < MAX_STEPS) begin
                    cnt_next  = cnt_reg + 8'd1;
                    last_next = in;
                end else begin
                    state_next = WAIT0;
                    err_next   = 1'b1;
                end
            end
            WAIT0: begin
                if (in == ZERO_LEVEL) state_next = IDLE;
            end
            default: state_next = SYNC;
        endcase
        ovf_next = load && full && !free;
    end

    dav_producer u_producer (
        .clock  (clock),
        .reset_ (reset_),
        .load   (load),
        .data   ({dir_reg, cnt_reg[6:0]}),
        .rfd    (rfd),
        .dav_   (dav_),
        .s      (s),
        .h      (h),
        .full   (full),
        .free   (free)
    );

    assign err = err_reg;
    assign ovf = ovf_reg;

endmodule

// File: tb/tb_triangle_decoder.sv
// Directed bench for triangle_decoder: each task drives line samples and
// checks outputs 1 time unit after the sampling edge.
module tb_triangle_decoder;

    logic       clock = 1'b0;
    logic       reset_ = 1'b0;
    logic       rfd = 1'b0;
    logic [7:0] line = 8'h80;
    logic       s;
    logic [6:0] h;
    logic       dav_;
    logic       err;
    logic       ovf;

    int compared = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    triangle_decoder dut (
        .clock  (clock),
        .reset_ (reset_),
        .in     (line),
        .s      (s),
        .h      (h),
        .dav_   (dav_),
        .rfd    (rfd),
        .err    (err),
        .ovf    (ovf)
    );

    task automatic send(input logic [7:0] v);
        @(negedge clock);
        line = v;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic err_seen;
        reset_ = 1'b0;
        line = 8'h80;
        repeat (2) @(posedge clock);
        #1;
        compared++; if (dav_ !== 1'b1) begin mismatched++; $display("FAIL reset_dav: got %b expected 1", dav_); end
        compared++; if (s !== 1'b0) begin mismatched++; $display("FAIL reset_s: got %b expected 0", s); end
        compared++; if (h !== 7'd0) begin mismatched++; $display("FAIL reset_h: got %0d expected 0", h); end
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b expected 0", err); end
        compared++; if (ovf !== 1'b0) begin mismatched++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        // Release mid-pulse: SYNC must swallow these without error.
        @(negedge clock);
        line = 8'h82;
        reset_ = 1'b1;
        @(posedge clock);
        #1;
        err_seen = err;
        send(8'h83);
        err_seen |= err;
        compared++; if (err_seen !== 1'b0) begin mismatched++; $display("FAIL sync_no_err: got %b expected 0", err_seen); end
        send(8'h80);
        $display("test_reset done");
    endtask

    task automatic test_basic();
        rfd = 1'b1;
        send(8'h81); send(8'h82); send(8'h83); send(8'h80);
        compared++; if (s !== 1'b0) begin mismatched++; $display("FAIL basic_s: got %b expected 0", s); end
        compared++; if (h !== 7'd3) begin mismatched++; $display("FAIL basic_h: got %0d expected 3", h); end
        compared++; if (dav_ !== 1'b1) begin mismatched++; $display("FAIL basic_dav_at_load: got %b expected 1", dav_); end
        send(8'h80);
        compared++; if (dav_ !== 1'b0) begin mismatched++; $display("FAIL basic_dav_fall: got %b expected 0", dav_); end
        rfd = 1'b0;
        send(8'h80);
        compared++; if (dav_ !== 1'b1) begin mismatched++; $display("FAIL basic_dav_rise: got %b expected 1", dav_); end
        $display("test_basic done: s=%b h=%0d", s, h);
    endtask

    task automatic test_down();
        rfd = 1'b1;
        send(8'h7F); send(8'h7E); send(8'h80);
        compared++; if (s !== 1'b1) begin mismatched++; $display("FAIL down_s: got %b expected 1", s); end
        compared++; if (h !== 7'd2) begin mismatched++; $display("FAIL down_h: got %0d expected 2", h); end
        send(8'h80);
        compared++; if (dav_ !== 1'b0) begin mismatched++; $display("FAIL down_dav: got %b expected 0", dav_); end
        rfd = 1'b0;
        send(8'h80);
        $display("test_down done: s=%b h=%0d", s, h);
    endtask

    task automatic test_max_height();
        logic err_seen;
        rfd = 1'b1;
        err_seen = 1'b0;
        for (int i = 127; i >= 0; i--) begin
            send(8'(i));
            err_seen |= err;
        end
        send(8'h80);
        compared++; if (err_seen !== 1'b0) begin mismatched++; $display("FAIL max_down_err: got %b expected 0", err_seen); end
        compared++; if (s !== 1'b1) begin mismatched++; $display("FAIL max_down_s: got %b expected 1", s); end
        compared++; if (h !== 7'd0) begin mismatched++; $display("FAIL max_down_h: got %0d expected 0", h); end
        send(8'h80);
        rfd = 1'b0;
        send(8'h80);
        rfd = 1'b1;
        err_seen = 1'b0;
        for (int i = 129; i <= 256; i++) begin
            send(8'(i));
            err_seen |= err;
        end
        send(8'h80);
        compared++; if (err_seen !== 1'b0) begin mismatched++; $display("FAIL max_up_err: got %b expected 0", err_seen); end
        compared++; if (s !== 1'b0) begin mismatched++; $display("FAIL max_up_s: got %b expected 0", s); end
        compared++; if (h !== 7'd0) begin mismatched++; $display("FAIL max_up_h: got %0d expected 0", h); end
        send(8'h80);
        compared++; if (dav_ !== 1'b0) begin mismatched++; $display("FAIL max_up_dav: got %b expected 0", dav_); end
        rfd = 1'b0;
        send(8'h80);
        $display("test_max_height done: s=%b h=%0d", s, h);
    endtask

    task automatic test_errors();
        rfd = 1'b1;
        send(8'h81); send(8'h83);
        compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL step_err: got %b expected 1", err); end
        send(8'h80);
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL step_err_pulse: got %b expected 0", err); end
        send(8'h80);
        compared++; if (dav_ !== 1'b1) begin mismatched++; $display("FAIL step_err_dav: got %b expected 1", dav_); end
        send(8'h81); send(8'h80);
        compared++; if (h !== 7'd1) begin mismatched++; $display("FAIL after_err_h: got %0d expected 1", h); end
        compared++; if (s !== 1'b0) begin mismatched++; $display("FAIL after_err_s: got %b expected 0", s); end
        send(8'h80);
        rfd = 1'b0;
        send(8'h80);
        // 129th ramp sample is malformed even though the step is correct.
        rfd = 1'b1;
        for (int i = 129; i <= 256; i++) send(8'(i));
        send(8'h01);
        compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL overlong_err: got %b expected 1", err); end
        send(8'h80); send(8'h80);
        compared++; if (dav_ !== 1'b1) begin mismatched++; $display("FAIL overlong_dav: got %b expected 1", dav_); end
        send(8'h85);
        compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL bad_start_err: got %b expected 1", err); end
        send(8'h86);
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL wait0_no_err: got %b expected 0", err); end
        send(8'h80);
        $display("test_errors done");
    endtask

    task automatic test_ovf();
        rfd = 1'b0;
        send(8'h81); send(8'h82); send(8'h80);
        compared++; if (h !== 7'd2) begin mismatched++; $display("FAIL ovf_first_h: got %0d expected 2", h); end
        send(8'h7F); send(8'h80);
        compared++; if (ovf !== 1'b1) begin mismatched++; $display("FAIL ovf_pulse: got %b expected 1", ovf); end
        compared++; if (s !== 1'b0 || h !== 7'd2) begin mismatched++; $display("FAIL ovf_hold: got s=%b h=%0d expected s=0 h=2", s, h); end
        rfd = 1'b1;
        send(8'h80);
        compared++; if (ovf !== 1'b0) begin mismatched++; $display("FAIL ovf_one_clock: got %b expected 0", ovf); end
        compared++; if (dav_ !== 1'b0) begin mismatched++; $display("FAIL ovf_deliver: got %b expected 0", dav_); end
        rfd = 1'b0;
        send(8'h80);
        rfd = 1'b1;
        send(8'h80); send(8'h80);
        compared++; if (dav_ !== 1'b1) begin mismatched++; $display("FAIL ovf_single_delivery: got %b expected 1", dav_); end
        $display("test_ovf done");
    endtask

    task automatic test_back_to_back();
        rfd = 1'b1;
        send(8'h81); send(8'h80);
        send(8'h7F);
        compared++; if (dav_ !== 1'b0) begin mismatched++; $display("FAIL b2b_first_dav: got %b expected 0", dav_); end
        rfd = 1'b0;
        send(8'h80);
        compared++; if (ovf !== 1'b0) begin mismatched++; $display("FAIL b2b_free_same_edge_ovf: got %b expected 0", ovf); end
        compared++; if (s !== 1'b1 || h !== 7'd1) begin mismatched++; $display("FAIL b2b_second: got s=%b h=%0d expected s=1 h=1", s, h); end
        rfd = 1'b1;
        send(8'h80);
        compared++; if (dav_ !== 1'b0) begin mismatched++; $display("FAIL b2b_second_dav: got %b expected 0", dav_); end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid();
        logic err_seen;
        send(8'h81); send(8'h82);
        @(negedge clock);
        line = 8'h83;
        reset_ = 1'b0;
        #1;
        compared++; if (dav_ !== 1'b1 || s !== 1'b0 || h !== 7'd0) begin mismatched++; $display("FAIL async_reset: got dav_=%b s=%b h=%0d expected 1 0 0", dav_, s, h); end
        @(negedge clock);
        line = 8'h84;
        reset_ = 1'b1;
        @(posedge clock);
        #1;
        err_seen = err;
        send(8'h85); err_seen |= err;
        send(8'h86); err_seen |= err;
        compared++; if (err_seen !== 1'b0 || dav_ !== 1'b1) begin mismatched++; $display("FAIL post_reset_quiet: got err=%b dav_=%b expected 0 1", err_seen, dav_); end
        send(8'h80);
        send(8'h7F); send(8'h80);
        compared++; if (s !== 1'b1 || h !== 7'd1) begin mismatched++; $display("FAIL post_reset_pulse: got s=%b h=%0d expected s=1 h=1", s, h); end
        send(8'h80);
        compared++; if (dav_ !== 1'b0) begin mismatched++; $display("FAIL post_reset_dav: got %b expected 0", dav_); end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_down();
        test_max_height();
        test_errors();
        test_ovf();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
